// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive stages.
//   - rx_state_t  : receiver state encoding (IDLE, START, DATA, STOP)
//   - DATA_BITS   : payload bits per 8N1 frame
//   - FRAME_BITS  : total bits per 8N1 frame (start + data + stop)
//   - symbol_time : clock cycles per bit period
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clock cycles per symbol; shared with the transmitter so both ends agree.
    function automatic int unsigned symbol_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous UART line plus falling-edge detect.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-high reset (all flops reset to line idle = 1)
//   serial_in : raw asynchronous UART line
//   rx        : synchronized line (second synchronizer flop)
//   fall      : high while rx is 0 and the previous rx was 1
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic serial_in,
    output logic rx,
    output logic fall
);

    logic sync_q;
    logic prev_rx;

    // Reset to 1 so a reset never looks like a start-bit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 1'b1;
            rx      <= 1'b1;
            prev_rx <= 1'b1;
        end else begin
            sync_q  <= serial_in;
            rx      <= sync_q;
            prev_rx <= rx;
        end
    end

    assign fall = prev_rx & ~rx;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: serial line in, bytes out on a valid/ready interface.
// Optional error reporting is enabled by defining UART_RX_ERR_EN.
// Ports:
//   clk            : system clock
//   reset          : asynchronous active-high reset
//   serial_in      : asynchronous UART line, idle high
//   data_out       : received byte, stable while data_out_valid is high
//   data_out_valid : byte available
//   data_out_ready : consumer accepts the byte when valid && ready at posedge
//   framing_error  : (UART_RX_ERR_EN) one-cycle pulse when a stop bit reads 0
//   overrun        : (UART_RX_ERR_EN) one-cycle pulse when a good byte is dropped
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
`ifdef UART_RX_ERR_EN
    ,
    output logic                 framing_error,
    output logic                 overrun
`endif
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    // Bit index spans the data field between the start and stop bits.
    localparam int unsigned BIT_W            = $clog2(FRAME_BITS - 2);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);

    logic                 rx;
    logic                 fall;
    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_stb;   // a stop bit was sampled last edge
    logic                 stop_ok;    // value of that stop bit

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .rx        (rx),
        .fall      (fall)
    );

    // Frame FSM: START samples mid start bit, then every symbol lands mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            stop_stb <= 1'b0;
            stop_ok  <= 1'b0;
        end else begin
            stop_stb <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == SAMPLE_LAST) begin
                        clk_cnt <= '0;
                        if (!rx) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == SYMBOL_LAST) begin
                        clk_cnt <= '0;
                        shift_q <= {rx, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == SYMBOL_LAST) begin
                        clk_cnt  <= '0;
                        stop_stb <= 1'b1;
                        stop_ok  <= rx;
                        state    <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Output holding register; a held byte wins over a newly arrived one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (stop_stb && stop_ok && (!data_out_valid || data_out_ready)) begin
            data_out       <= shift_q;
            data_out_valid <= 1'b1;
        end else if (data_out_valid && data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

`ifdef UART_RX_ERR_EN
    // Error pulses line up with the edge a good byte would have been loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= stop_stb & ~stop_ok;
            overrun       <= stop_stb & stop_ok & data_out_valid & ~data_out_ready;
        end
    end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int unsigned CF  = 200;
    localparam int unsigned BR  = 10;
    localparam int unsigned T   = CF / BR;          // cycles per bit
    localparam int unsigned S   = T / 2;            // cycles to mid start bit
    // 2 sync flops + edge decision + half symbol + 9 symbols + output register
    localparam int unsigned LAT = 4 + S + 9 * T;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
`ifdef UART_RX_ERR_EN
    logic       framing_error;
    logic       overrun;
`endif

    uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef UART_RX_ERR_EN
        ,
        .framing_error  (framing_error),
        .overrun        (overrun)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frames to send and expected byte arrivals.
    typedef struct {
        logic [7:0] d;
        bit         stop;
        int         glitch;   // >0: just a low pulse of this many cycles
        int         gap;      // idle cycles after the item
        int         rst_bit;  // >=0: pulse reset in the middle of this frame bit
    } tx_t;

    typedef struct {
        int         at;
        logic [7:0] d;
        bit         good;
    } ev_t;

    tx_t  txq[$];
    ev_t  pend[$];
    tx_t  cur;
    bit   tx_busy = 1'b0;
    int   last_p  = 0;
    logic [9:0] bits;

    // Behavioural line driver; also owns reset.
    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (txq.size() != 0) begin
                cur     = txq.pop_front();
                tx_busy = 1'b1;
                last_p  = cyc;
                if (cur.glitch > 0) begin
                    serial_in = 1'b0;
                    repeat (cur.glitch) @(posedge clk);
                    #1 serial_in = 1'b1;
                end else begin
                    pend.push_back('{at: last_p + LAT, d: cur.d, good: cur.stop});
                    bits = {cur.stop, cur.d, 1'b0};
                    for (int b = 0; b < 10; b++) begin
                        serial_in = bits[b];
                        if (b == cur.rst_bit) begin
                            repeat (T / 2) @(posedge clk);
                            #1;
                            reset     = 1'b1;
                            serial_in = 1'b1;
                            #1;
                            chk("rst_async_valid", 32'(data_out_valid), 32'd0);
                            chk("rst_async_data", 32'(data_out), 32'h00);
`ifdef UART_RX_ERR_EN
                            chk("rst_async_ferr", 32'(framing_error), 32'd0);
                            chk("rst_async_ovr", 32'(overrun), 32'd0);
`endif
                            repeat (3) @(posedge clk);
                            #1 reset = 1'b0;
                            break;
                        end
                        repeat (T - 1) @(posedge clk);
                        if (b != 9) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                if (cur.gap > 0) begin
                    @(posedge clk);
                    #1 serial_in = 1'b1;
                    repeat (cur.gap - 1) @(posedge clk);
                end
                tx_busy = 1'b0;
            end
        end
    end

    // Reference model: byte arrivals at fixed latency into a one-entry holding slot.
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         r_last  = 1'b0;
    bit         arr;
    bit         arr_good;
    logic [7:0] arr_d;
`ifdef UART_RX_ERR_EN
    bit         m_ferr;
    bit         m_ovr;
`endif

    always @(negedge clk) begin
        arr      = 1'b0;
        arr_good = 1'b0;
        arr_d    = 8'h00;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            pend.delete();
        end else begin
            while (pend.size() != 0 && pend[0].at <= cyc) begin
                if (pend[0].at == cyc) begin
                    arr      = 1'b1;
                    arr_good = pend[0].good;
                    arr_d    = pend[0].d;
                end
                void'(pend.pop_front());
            end
        end
`ifdef UART_RX_ERR_EN
        m_ferr = !reset && arr && !arr_good;
        m_ovr  = !reset && arr && arr_good && m_valid && !r_last;
`endif
        if (!reset) begin
            if (arr && arr_good && (!m_valid || r_last)) begin
                m_data  = arr_d;
                m_valid = 1'b1;
            end else if (m_valid && r_last) begin
                m_valid = 1'b0;
            end
        end
        chk("valid", 32'(data_out_valid), 32'(m_valid));
        chk("data", 32'(data_out), 32'(m_data));
`ifdef UART_RX_ERR_EN
        chk("framing_error", 32'(framing_error), 32'(m_ferr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
        r_last = data_out_ready;
    end

    task automatic send(input logic [7:0] d, input bit stop, input int gap);
        txq.push_back('{d: d, stop: stop, glitch: 0, gap: gap, rst_bit: -1});
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (data_out_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            if (txq.size() == 0 && !tx_busy && pend.size() == 0) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // One frame with ready held high: literal byte, exact latency, single-cycle pulse.
    task automatic loop_one(input string name, input logic [7:0] d);
        bit seen;
        send(d, 1'b1, T);
        wait_valid(LAT + 3 * T, seen);
        chk({name, "_seen"}, 32'(seen), 32'd1);
        chk({name, "_byte"}, 32'(data_out), 32'(d));
        chk({name, "_lat"}, 32'(cyc - last_p), 32'(LAT));
        @(negedge clk);
        chk({name, "_pulse"}, 32'(data_out_valid), 32'd0);
        wait_idle({name, "_idle"}, 20 * T);
    endtask

    initial begin
        bit seen;
        data_out_ready = 1'b1;
        #2;
        chk("reset_valid", 32'(data_out_valid), 32'd0);
        chk("reset_data", 32'(data_out), 32'h00);
        repeat (6) @(posedge clk);
        #1;

        loop_one("loop55", 8'h55);
        loop_one("loopA5", 8'hA5);
        loop_one("loop00", 8'h00);

        // Short low pulse must be rejected at the mid-start check.
        txq.push_back('{d: 8'h00, stop: 1'b1, glitch: S - 4, gap: 2 * T, rst_bit: -1});
        wait_valid(12 * T, seen);
        chk("glitch_no_valid", 32'(seen), 32'd0);
        loop_one("after_glitch3C", 8'h3C);

        // Back-to-back frames, no idle gap.
        send(8'hFF, 1'b1, 0);
        send(8'h01, 1'b1, T);
        wait_valid(LAT + 3 * T, seen);
        chk("b2b_first", 32'(data_out), 32'h0000_00FF);
        @(negedge clk);
        wait_valid(12 * T, seen);
        chk("b2b_second", 32'(data_out), 32'h0000_0001);
        wait_idle("b2b_idle", 20 * T);

        // Overrun: second byte dropped while the first is held.
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        send(8'h12, 1'b1, 0);
        send(8'h34, 1'b1, T);
        wait_idle("ovr_idle", 40 * T);
        repeat (T) @(negedge clk);
        chk("ovr_held_valid", 32'(data_out_valid), 32'd1);
        chk("ovr_held_byte", 32'(data_out), 32'h0000_0012);
        @(posedge clk);
        #1 data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_drained", 32'(data_out_valid), 32'd0);

        // Framing error: stop bit low, byte discarded.
        send(8'hA5, 1'b0, 2 * T);
        wait_valid(LAT + 4 * T, seen);
        chk("frame_no_valid", 32'(seen), 32'd0);
        wait_idle("frame_idle", 20 * T);
        loop_one("after_frame5A", 8'h5A);

        // Reset in the middle of data bit 4 while a byte is held.
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        send(8'h77, 1'b1, T);
        wait_idle("rst_pre_idle", 20 * T);
        chk("rst_pre_held", 32'(data_out_valid), 32'd1);
        txq.push_back('{d: 8'hE7, stop: 1'b1, glitch: 0, gap: 12 * T, rst_bit: 5});
        wait_idle("rst_idle", 30 * T);
        chk("rst_after_valid", 32'(data_out_valid), 32'd0);
        @(posedge clk);
        #1 data_out_ready = 1'b1;
        loop_one("after_rstC3", 8'hC3);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            if (kind == 0) begin
                txq.push_back('{d: 8'h00, stop: 1'b1, glitch: int'($urandom_range(1, S - 2)),
                                gap: T + int'($urandom_range(0, T)), rst_bit: -1});
            end else if (kind == 1) begin
                send(8'($urandom), 1'b0, T + int'($urandom_range(0, T)));
            end else begin
                send(8'($urandom), 1'b1, int'($urandom_range(0, 2 * T)));
            end
        end
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 40 * 14 * T && !done; i++) begin
                @(posedge clk);
                #1 data_out_ready = 1'($urandom_range(0, 1));
                if (txq.size() == 0 && !tx_busy && pend.size() == 0) done = 1'b1;
            end
            chk("random_drain", 32'(done), 32'd1);
        end
        data_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_empty", 32'(data_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
